// File: rtl/mips_test_sequencer.sv
// Load/run/check harness for the 5-stage MIPS pipeline: copies a program ROM into instruction memory,
// runs the CPU for a set number of cycles, then compares its registers. Optional macro: TEST_SEQ_MASK_EN.
module mips_test_sequencer #(
  parameter int PROG_DEPTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  localparam int AW        = $clog2(PROG_DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [AW:0]       i_prog_len,
  input  logic [CNT_W-1:0]  i_run_cycles,
  output logic [AW-1:0]     o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic [4:0]        o_exp_addr,
  input  logic [DATA_W-1:0] i_exp_data,
`ifdef TEST_SEQ_MASK_EN
  input  logic [NUM_REGS-1:0] i_exp_mask,
`endif
  output logic              o_imem_we,
  output logic [AW-1:0]     o_imem_addr,
  output logic [DATA_W-1:0] o_imem_wdata,
  output logic              o_cpu_rst,
  output logic              o_cpu_run,
  output logic [4:0]        o_rf_raddr,
  input  logic [DATA_W-1:0] i_rf_rdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [5:0]        o_mismatch_count,
  output logic [4:0]        o_first_fail_reg,
  output logic [CNT_W-1:0]  o_cycle_count,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CHECK, S_DONE} state_t;

  localparam logic [AW-1:0] LAST_K   = AW'(PROG_DEPTH - 1);
  localparam logic [4:0]    LAST_REG = 5'(NUM_REGS - 1);
  localparam logic [AW:0]   PD_LEN   = (AW+1)'(PROG_DEPTH);

  state_t            r_state, w_next;
  logic [AW:0]       r_eff_len;
  logic [CNT_W-1:0]  r_run_cycles, r_cycle_count, w_cnt_inc;
  logic [AW-1:0]     r_k, r_imem_addr;
  logic              r_load_act, r_imem_we;
  logic [4:0]        r_i, r_cmp_idx;
  logic              r_chk_act, r_cmp_v;
  logic [DATA_W-1:0] r_rf_q;
  logic [5:0]        r_mismatch;
  logic [4:0]        r_first_fail;
  logic              w_accept, w_issue, w_mask_bit, w_cmp_fail, w_imem_we;

`ifdef TEST_SEQ_MASK_EN
  logic [31:0] r_mask;
  assign w_mask_bit = r_mask[r_cmp_idx];
`else
  assign w_mask_bit = 1'b1;
`endif

  // start is a single-cycle request with no ready: it is taken only in IDLE or DONE and
  // silently dropped while busy; reset in the same cycle drops it as well.
  assign w_accept   = i_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_issue    = (r_state == S_CHECK) && r_chk_act;
  assign w_cnt_inc  = r_cycle_count + 1'b1;
  assign w_cmp_fail = r_cmp_v && w_mask_bit && (r_rf_q != i_exp_data);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_accept) w_next = S_LOAD;
      S_LOAD: begin
        if (r_imem_we && r_imem_addr == LAST_K)
          w_next = (r_run_cycles == '0) ? S_CHECK : S_RUN;
      end
      S_RUN:   if (w_cnt_inc == r_run_cycles) w_next = S_CHECK;
      S_CHECK: if (r_cmp_v && r_cmp_idx == LAST_REG) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_eff_len     <= '0;
      r_run_cycles  <= '0;
      r_cycle_count <= '0;
      r_k           <= '0;
      r_imem_addr   <= '0;
      r_load_act    <= 1'b0;
      r_imem_we     <= 1'b0;
      r_i           <= '0;
      r_cmp_idx     <= '0;
      r_chk_act     <= 1'b0;
      r_cmp_v       <= 1'b0;
      r_rf_q        <= '0;
      r_mismatch    <= '0;
      r_first_fail  <= '0;
`ifdef TEST_SEQ_MASK_EN
      r_mask        <= '0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_eff_len     <= (i_prog_len > PD_LEN) ? PD_LEN : i_prog_len;
        r_run_cycles  <= i_run_cycles;
        r_cycle_count <= '0;
        r_k           <= '0;
        r_load_act    <= 1'b1;
        r_i           <= '0;
        r_chk_act     <= 1'b1;
        r_mismatch    <= '0;
        r_first_fail  <= '0;
`ifdef TEST_SEQ_MASK_EN
        r_mask        <= 32'(i_exp_mask);
`endif
      end
      // The write for ROM address k lands one cycle later, once the ROM data is valid.
      r_imem_we <= (r_state == S_LOAD) && r_load_act;
      if (r_state == S_LOAD && r_load_act) begin
        r_imem_addr <= r_k;
        if (r_k == LAST_K) r_load_act <= 1'b0;
        else               r_k        <= r_k + 1'b1;
      end
      if (r_state == S_RUN) r_cycle_count <= w_cnt_inc;
      // Register-file data is delayed a cycle to meet the expected-value ROM output.
      r_cmp_v <= w_issue;
      if (w_issue) begin
        r_cmp_idx <= r_i;
        r_rf_q    <= i_rf_rdata;
        if (r_i == LAST_REG) r_chk_act <= 1'b0;
        else                 r_i       <= r_i + 1'b1;
      end
      if (w_cmp_fail) begin
        if (r_mismatch == 6'd0)  r_first_fail <= r_cmp_idx;
        if (r_mismatch != 6'd63) r_mismatch   <= r_mismatch + 1'b1;
      end
    end
  end

  assign w_imem_we        = r_imem_we && !i_reset;
  assign o_imem_we        = w_imem_we;
  assign o_imem_addr      = r_imem_addr;
  assign o_imem_wdata     = (w_imem_we && ({1'b0, r_imem_addr} < r_eff_len)) ? i_rom_data : '0;
  assign o_rom_addr       = r_k;
  assign o_exp_addr       = r_i;
  assign o_rf_raddr       = r_i;
  assign o_cpu_rst        = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign o_cpu_run        = (r_state == S_RUN);
  assign o_busy           = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_CHECK);
  assign o_done           = (r_state == S_DONE);
  assign o_pass           = (r_state == S_DONE) && (r_mismatch == 6'd0);
  assign o_mismatch_count = r_mismatch;
  assign o_first_fail_reg = r_first_fail;
  assign o_cycle_count    = r_cycle_count;
  assign o_dbg_state      = r_state;

endmodule
